scalar_alu_arbiter: RTL
=======================

Name: scalar_alu_arbiter

Overview:
- Shares one scalar ALU instance (ADD/SUB, shifts, compares, logic, branch compare) between NUM_REQ requesters, e.g. warp issue slots.
- Round-robin arbitration; at most one operation issued per cycle.
- Registered single-entry result stage with valid/ready handshake, tagged with requester ID and a caller tag.
- Sits between the warp issue stage and scalar writeback/branch resolution.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TAG_W, 6, width of the opaque caller tag returned with the result.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i].
- req_op_b  in  NUM_REQ*32  operand B.
- req_funct3  in  NUM_REQ*3  ALU funct3.
- req_is_sub  in  NUM_REQ  SUB/SRA select.
- req_opcode  in  NUM_REQ*7  opcode; OP_BRANCH selects compare mode.
- req_tag  in  NUM_REQ*TAG_W  opaque tag.
- flush  in  1  synchronous kill of the result stage.
- rsp_valid  out  1  result stage holds a result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  32  ALU result (0 for branches).
- rsp_branch_taken  out  1  branch compare outcome.
- rsp_is_branch  out  1  opcode was OP_BRANCH.
- rsp_req_id  out  $clog2(NUM_REQ)  index of the originating requester.
- rsp_tag  out  TAG_W  tag of the originating request.

Behaviour:
- Reset (async): rr_ptr=0; rsp_valid=0; all rsp_* data=0; req_ready=0.
- can_issue = !rsp_valid || rsp_ready, and !flush.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[i] = grant[i] & can_issue. req_ready must never depend on req_valid of a different requester being deasserted.
- Handshake: requester holds valid and payload stable until req_ready; transfer occurs on valid & ready.
- On a transfer from requester g:
  - Muxed operands drive the internal ALU.
  - At the next edge: rsp_result, rsp_branch_taken, rsp_is_branch, rsp_req_id=g, rsp_tag are registered; rsp_valid=1; rr_ptr=(g+1) mod NUM_REQ.
  - Latency: accept at cycle T, rsp_valid high at T+1.
- rr_ptr is unchanged when no transfer occurs.
- Output stall: rsp_valid & !rsp_ready means all rsp_* hold stable and no grant is issued. rsp_valid & rsp_ready with a new transfer in the same cycle gives back-to-back results, full throughput.
- rsp_valid & rsp_ready with no transfer: rsp_valid=0 next cycle; data regs may hold.
- flush=1: rsp_valid=0 next cycle regardless of rsp_ready; no request is accepted in that cycle; rr_ptr unchanged.
- ALU semantics:
  - 32-bit, two's complement wrap on ADD/SUB.
  - Shift amount = op_b[4:0].
  - SLT/BLT/BGE signed; SLTU/BLTU/BGEU unsigned.
  - Branch funct3 010/011 yields taken=0.
  - Non-branch result for branch opcodes = 0.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,…,NUM_REQ-1 with no requester starved more than NUM_REQ-1 grants.

Optional Feature:
- SCALAR_ALU_ARB_PERF_EN defined: adds outputs perf_issue_cnt (32) and perf_stall_cnt (32).
  - perf_issue_cnt increments on every transfer.
  - perf_stall_cnt increments each cycle where |req_valid and no transfer occurs.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package (isa_pkg): OP_BRANCH and the other opcode constants, plus funct3 localparams (F3_ADD, F3_SLL, … F3_BGEU) used by the bench.
- One natural sub-module: rr_arbiter (req vector, ptr, can_issue → one-hot grant, grant index); reusable elsewhere.
- The existing scalar ALU is instantiated unmodified as the datapath.

Test Plan:
- Single requester: req1 ADD 5+7 tag=3 → rsp_valid at T+1, result=12, req_id=1, tag=3.
- SUB/SRA/SLTU: 0x80000000 SRA 4 → 0xF8000000; 1 SLTU 0xFFFFFFFF → 1; 0-1 → 0xFFFFFFFF.
- Branch: opcode=OP_BRANCH, funct3=100, a=-1, b=1 → branch_taken=1, result=0, is_branch=1.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; one result per cycle.
- rsp_ready=0 for 3 cycles with a result held → rsp_* stable, req_ready=0; ready high → next grant issued in that same cycle.
- flush while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 next cycle, no request accepted; async rst mid-stream → all outputs 0 immediately, rr_ptr=0.

Source files
------------

// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared opcode and funct3 constants for the scalar ALU and its arbiter.
// It also defines the ALU response bundle and a small index-wrap helper.
// No ports: this file is a package only.
// -----------------------------------------------------------------------------
package isa_pkg;

   // Major opcodes
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3 (010 and 011 are unused and never taken)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic        is_branch;
      logic        branch_taken;
      logic [31:0] result;
   } alu_rsp_t;

   // Returns idx+1 wrapped to [0, n-1]; used for the round-robin pointer.
   function automatic int wrap_inc(input int idx, input int n);
      int nxt;
      nxt = idx + 1;
      if (nxt >= n) begin
         nxt = 0;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/scalar_alu.sv
// -----------------------------------------------------------------------------
// scalar_alu
// Combinational 32-bit scalar ALU. It covers add/sub, shifts, set-less-than,
// logic operations and branch compares.
// Ports:
//   i_op_a, i_op_b   operands
//   i_funct3         operation select
//   i_is_sub         SUB for ADD, SRA for SRL
//   i_opcode         OP_BRANCH selects compare mode (the result is then 0)
//   o_result         ALU result
//   o_branch_taken   branch compare outcome
//   o_is_branch      opcode was OP_BRANCH
// -----------------------------------------------------------------------------
module scalar_alu
   import isa_pkg::*;
(
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic [2:0]  i_funct3,
   input  logic        i_is_sub,
   input  logic [6:0]  i_opcode,
   output logic [31:0] o_result,
   output logic        o_branch_taken,
   output logic        o_is_branch
);

   logic [4:0]  w_shamt;
   logic [31:0] w_sum;
   logic        w_lt_s;
   logic        w_lt_u;
   logic        w_eq;

   assign w_shamt     = i_op_b[4:0];
   assign w_lt_s      = $signed(i_op_a) < $signed(i_op_b);
   assign w_lt_u      = i_op_a < i_op_b;
   assign w_eq        = i_op_a == i_op_b;
   assign o_is_branch = i_opcode == OP_BRANCH;

   // Adder shared by ADD and SUB
   always_comb begin
      if (i_is_sub) begin
         w_sum = i_op_a - i_op_b;
      end else begin
         w_sum = i_op_a + i_op_b;
      end
   end

   // Result and branch decision
   always_comb begin
      o_result       = 32'd0;
      o_branch_taken = 1'b0;
      if (o_is_branch) begin
         case (i_funct3)
            F3_BEQ:  o_branch_taken = w_eq;
            F3_BNE:  o_branch_taken = ~w_eq;
            F3_BLT:  o_branch_taken = w_lt_s;
            F3_BGE:  o_branch_taken = ~w_lt_s;
            F3_BLTU: o_branch_taken = w_lt_u;
            F3_BGEU: o_branch_taken = ~w_lt_u;
            default: o_branch_taken = 1'b0;
         endcase
      end else begin
         case (i_funct3)
            F3_ADD:  o_result = w_sum;
            F3_SLL:  o_result = i_op_a << w_shamt;
            F3_SLT:  o_result = {31'd0, w_lt_s};
            F3_SLTU: o_result = {31'd0, w_lt_u};
            F3_XOR:  o_result = i_op_a ^ i_op_b;
            F3_SRL: begin
               if (i_is_sub) begin
                  o_result = $signed(i_op_a) >>> w_shamt;
               end else begin
                  o_result = i_op_a >> w_shamt;
               end
            end
            F3_OR:   o_result = i_op_a | i_op_b;
            F3_AND:  o_result = i_op_a & i_op_b;
            default: o_result = 32'd0;
         endcase
      end
   end

endmodule

// File: rtl/scalar_alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant logic. Priority starts at i_ptr and wraps modulo NUM_REQ.
// Ports:
//   i_req          request vector
//   i_ptr          highest-priority index this cycle
//   i_can_issue    grant enable; when low, o_grant is all zero
//   o_grant        one-hot grant (already gated by i_can_issue)
//   o_grant_idx    index of the winner (valid when o_grant_valid)
//   o_grant_valid  some request won arbitration, independent of i_can_issue
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   input  logic               i_can_issue,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_grant_idx,
   output logic               o_grant_valid
);

   int w_idx;

   // Scan from the pointer and take the first active request
   always_comb begin
      o_grant       = '0;
      o_grant_idx   = '0;
      o_grant_valid = 1'b0;
      w_idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_grant_valid && i_req[w_idx]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = IW'(w_idx);
         end else begin
            o_grant_valid = o_grant_valid;
         end
      end
      o_grant[o_grant_idx] = o_grant_valid & i_can_issue;
   end

endmodule

// File: rtl/scalar_alu_arbiter.sv
// -----------------------------------------------------------------------------
// scalar_alu_arbiter
// Shares one scalar ALU between NUM_REQ requesters using round-robin
// arbitration. At most one operation is accepted per cycle. Results land in a
// registered single-entry stage with a valid/ready handshake. Each result is
// tagged with the requester index and the caller tag.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_op_a/op_b        32-bit operands, requester i at [32i+31:32i]
//   req_funct3/is_sub    ALU operation select
//   req_opcode           OP_BRANCH selects compare mode
//   req_tag              opaque caller tag
//   flush                kills the result stage and blocks acceptance this cycle
//   rsp_*                registered result stage
//
// Optional feature: when SCALAR_ALU_ARB_PERF_EN is defined, two 32-bit
// counters are added. perf_issue_cnt counts transfers. perf_stall_cnt counts
// cycles with a pending request but no transfer.
// -----------------------------------------------------------------------------
module scalar_alu_arbiter
   import isa_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 6
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*32-1:0]      req_op_a,
   input  logic [NUM_REQ*32-1:0]      req_op_b,
   input  logic [NUM_REQ*3-1:0]       req_funct3,
   input  logic [NUM_REQ-1:0]         req_is_sub,
   input  logic [NUM_REQ*7-1:0]       req_opcode,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   input  logic                       flush,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_result,
   output logic                       rsp_branch_taken,
   output logic                       rsp_is_branch,
   output logic [$clog2(NUM_REQ)-1:0] rsp_req_id,
   output logic [TAG_W-1:0]           rsp_tag
`ifdef SCALAR_ALU_ARB_PERF_EN
   ,
   output logic [31:0]                perf_issue_cnt,
   output logic [31:0]                perf_stall_cnt
`endif
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0]      r_rr_ptr;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_result;
   logic               r_rsp_branch_taken;
   logic               r_rsp_is_branch;
   logic [IW-1:0]      r_rsp_req_id;
   logic [TAG_W-1:0]   r_rsp_tag;

   logic               w_can_issue;
   logic [NUM_REQ-1:0] w_grant;
   logic [IW-1:0]      w_grant_idx;
   logic               w_grant_valid;
   logic               w_transfer;
   logic [IW-1:0]      w_ptr_next;

   logic [31:0]        w_op_a;
   logic [31:0]        w_op_b;
   logic [2:0]         w_funct3;
   logic               w_is_sub;
   logic [6:0]         w_opcode;
   logic [TAG_W-1:0]   w_tag;
   alu_rsp_t           w_alu;

   // rst gates acceptance so req_ready reads zero while reset is held.
   assign w_can_issue = ~rst & (~r_rsp_valid | rsp_ready) & ~flush;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_arbiter (
      .i_req         (req_valid),
      .i_ptr         (r_rr_ptr),
      .i_can_issue   (w_can_issue),
      .o_grant       (w_grant),
      .o_grant_idx   (w_grant_idx),
      .o_grant_valid (w_grant_valid)
   );

   assign req_ready  = w_grant;
   assign w_transfer = |w_grant;
   assign w_ptr_next = IW'(wrap_inc(int'(w_grant_idx), NUM_REQ));

   // Operand mux steered by the winning index
   always_comb begin
      w_op_a   = req_op_a[32*int'(w_grant_idx) +: 32];
      w_op_b   = req_op_b[32*int'(w_grant_idx) +: 32];
      w_funct3 = req_funct3[3*int'(w_grant_idx) +: 3];
      w_is_sub = req_is_sub[w_grant_idx];
      w_opcode = req_opcode[7*int'(w_grant_idx) +: 7];
      w_tag    = req_tag[TAG_W*int'(w_grant_idx) +: TAG_W];
   end

   scalar_alu u_scalar_alu (
      .i_op_a         (w_op_a),
      .i_op_b         (w_op_b),
      .i_funct3       (w_funct3),
      .i_is_sub       (w_is_sub),
      .i_opcode       (w_opcode),
      .o_result       (w_alu.result),
      .o_branch_taken (w_alu.branch_taken),
      .o_is_branch    (w_alu.is_branch)
   );

   // Round-robin pointer moves past the winner only on a transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_transfer) begin
         r_rr_ptr <= w_ptr_next;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end

   // Result stage: load on transfer, drop on flush or consume, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid        <= 1'b0;
         r_rsp_result       <= 32'd0;
         r_rsp_branch_taken <= 1'b0;
         r_rsp_is_branch    <= 1'b0;
         r_rsp_req_id       <= '0;
         r_rsp_tag          <= '0;
      end else if (w_transfer) begin
         r_rsp_valid        <= 1'b1;
         r_rsp_result       <= w_alu.result;
         r_rsp_branch_taken <= w_alu.branch_taken;
         r_rsp_is_branch    <= w_alu.is_branch;
         r_rsp_req_id       <= w_grant_idx;
         r_rsp_tag          <= w_tag;
      end else if (flush | rsp_ready) begin
         r_rsp_valid        <= 1'b0;
      end else begin
         r_rsp_valid        <= r_rsp_valid;
      end
   end

   assign rsp_valid        = r_rsp_valid;
   assign rsp_result       = r_rsp_result;
   assign rsp_branch_taken = r_rsp_branch_taken;
   assign rsp_is_branch    = r_rsp_is_branch;
   assign rsp_req_id       = r_rsp_req_id;
   assign rsp_tag          = r_rsp_tag;

`ifdef SCALAR_ALU_ARB_PERF_EN
   logic [31:0] r_perf_issue_cnt;
   logic [31:0] r_perf_stall_cnt;

   // Issue and stall counters, free-running with natural wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_issue_cnt <= 32'd0;
         r_perf_stall_cnt <= 32'd0;
      end else if (w_transfer) begin
         r_perf_issue_cnt <= r_perf_issue_cnt + 32'd1;
         r_perf_stall_cnt <= r_perf_stall_cnt;
      end else if (|req_valid) begin
         r_perf_issue_cnt <= r_perf_issue_cnt;
         r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end else begin
         r_perf_issue_cnt <= r_perf_issue_cnt;
         r_perf_stall_cnt <= r_perf_stall_cnt;
      end
   end

   assign perf_issue_cnt = r_perf_issue_cnt;
   assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
